fmap_bank_pool: RTL

- Parametrised multi-channel feature-map store for a convolution layer output; successor to the fixed 8-channel layer memory.
- Accumulates partial sums per channel/pixel with bias seeding and saturation.
- Performs in-place 2x2 max-pool with optional ReLU, driven by a single pool FSM shared by all channels, with one aggregated done flag.
- Serves two registered read ports that return all channels in parallel for the next layer.

---
 rtl/fmap_pkg.sv | 33 +++
 rtl/fmap_channel.sv | 73 +++++++
 rtl/fmap_bank_pool.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fmap_pkg.sv
// Shared types and helpers for the pooled feature-map bank.
package fmap_pkg;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int PIX       = DEF_IMG_W * DEF_IMG_H;
  localparam int PW        = DEF_IMG_W / 2;
  localparam int PH        = DEF_IMG_H / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_WR,
    S_DONE
  } pool_state_t;

  // Exact signed add, clamped to the signed range of 'width' bits.
  function automatic int sat_add(int a, int b, int width);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fmap_channel.sv
// One output channel: pixel storage, accumulate/saturate write path,
// two registered read ports and the running-max / ReLU unit used by pooling.
module fmap_channel
  import fmap_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int NPIX    = 784,
  parameter int RELU_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_store,
  input  logic              i_first,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_bias,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_load,
  input  logic              i_a1_ok,
  input  logic              i_a2_ok,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic              i_max_init,
  input  logic              i_max_upd,
  input  logic [ADDR_W-1:0] i_pool_addr,
  input  logic              i_pool_wr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);

  logic        [DATA_W-1:0] r_mem [NPIX];
  logic signed [DATA_W-1:0] r_max;
  logic signed [DATA_W-1:0] w_base;
  logic signed [DATA_W-1:0] w_val;
  logic signed [DATA_W-1:0] w_pool_rd;
  logic        [DATA_W-1:0] w_sum;
  logic        [DATA_W-1:0] w_pooled;

  assign w_base    = i_first ? $signed(i_bias) : $signed(r_mem[i_st_addr]);
  assign w_val     = $signed(i_value);
  assign w_sum     = DATA_W'(sat_add(int'(w_base), int'(w_val), DATA_W));
  assign w_pool_rd = $signed(r_mem[i_pool_addr]);
  assign w_pooled  = ((RELU_EN != 0) && r_max[DATA_W-1]) ? '0 : r_max;

  always_ff @(posedge i_clk) begin
    if (i_max_init) begin
      r_max <= w_pool_rd;
    end else if (i_max_upd && (w_pool_rd > r_max)) begin
      r_max <= w_pool_rd;
    end
  end

  // Pool writes and stores never coincide: stores are only accepted while idle.
  always_ff @(posedge i_clk) begin
    if (i_pool_wr) begin
      r_mem[i_dst_addr] <= w_pooled;
    end else if (i_store) begin
      r_mem[i_st_addr] <= w_sum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd1 <= '0;
      o_rd2 <= '0;
    end else if (i_load) begin
      o_rd1 <= i_a1_ok ? r_mem[i_addr1] : '0;
      o_rd2 <= i_a2_ok ? r_mem[i_addr2] : '0;
    end
  end

endmodule

// File: rtl/fmap_bank_pool.sv
// Multi-channel feature-map bank: per-channel stores, dual parallel read ports
// and a single shared FSM that max-pools every channel 2x2 in place.
module fmap_bank_pool
  import fmap_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int ADDR_W  = 10,
  parameter int CH_W    = 3,
  parameter int RELU_EN = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_store,
  input  logic                     i_first,
  input  logic [CH_W-1:0]          i_out_c,
  input  logic [ADDR_W-1:0]        i_w_addr,
  input  logic [DATA_W-1:0]        i_bias,
  input  logic [DATA_W-1:0]        i_value,
  input  logic                     i_pool,
  output logic                     o_pool_busy,
  output logic                     o_pool_done,
  input  logic                     i_load,
  input  logic [ADDR_W-1:0]        i_addr1,
  input  logic [ADDR_W-1:0]        i_addr2,
  output logic [NUM_CH*DATA_W-1:0] o_rd_data1,
  output logic [NUM_CH*DATA_W-1:0] o_rd_data2,
  output logic                     o_rd_valid
);

  localparam int LP_PIX = IMG_W * IMG_H;
  localparam int LP_PW  = IMG_W / 2;
  localparam int LP_PH  = IMG_H / 2;
  localparam logic [ADDR_W-1:0] LP_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LP_ROW   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LP_ROW2  = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] LP_HALF  = ADDR_W'(LP_PW);
  localparam logic [ADDR_W-1:0] LP_LASTC = ADDR_W'(LP_PW - 1);
  localparam logic [ADDR_W-1:0] LP_LASTR = ADDR_W'(LP_PH - 1);

  pool_state_t       r_state;
  pool_state_t       w_next;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic              r_done;
  logic              r_valid;
  logic              w_idle;
  logic              w_last;
  logic              w_pool_go;
  logic              w_st_ok;
  logic              w_ld;
  logic              w_a1_ok;
  logic              w_a2_ok;
  logic [ADDR_W-1:0] w_src_base;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;

  assign w_idle    = (r_state == S_IDLE);
  assign w_last    = (r_row == LP_LASTR) && (r_col == LP_LASTC);
  assign w_pool_go = w_idle && i_pool;
  assign w_st_ok   = w_idle && i_store
                   && ({1'b0, i_out_c} < (CH_W + 1)'(NUM_CH))
                   && ({1'b0, i_w_addr} < (ADDR_W + 1)'(LP_PIX));
  assign w_ld      = w_idle && i_load;
  assign w_a1_ok   = ({1'b0, i_addr1} < (ADDR_W + 1)'(LP_PIX));
  assign w_a2_ok   = ({1'b0, i_addr2} < (ADDR_W + 1)'(LP_PIX));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_pool) w_next = S_RD0;
      S_RD0:   w_next = S_RD1;
      S_RD1:   w_next = S_RD2;
      S_RD2:   w_next = S_RD3;
      S_RD3:   w_next = S_WR;
      S_WR:    w_next = w_last ? S_DONE : S_RD0;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_ld;
      if (w_pool_go) begin
        r_row  <= '0;
        r_col  <= '0;
        r_done <= 1'b0;
      end else if (r_state == S_WR) begin
        if (w_last) r_done <= 1'b1;
        if (r_col == LP_LASTC) begin
          r_col <= '0;
          r_row <= r_row + LP_ONE;
        end else begin
          r_col <= r_col + LP_ONE;
        end
      end
    end
  end

  // Top-left source of the current 2x2 block; RD1..RD3 step right, down, down-right.
  assign w_src_base = (r_row * LP_ROW2) + (r_col << 1);
  assign w_dst      = (r_row * LP_HALF) + r_col;

  always_comb begin
    w_src = w_src_base;
    case (r_state)
      S_RD1:   w_src = w_src_base + LP_ONE;
      S_RD2:   w_src = w_src_base + LP_ROW;
      S_RD3:   w_src = w_src_base + LP_ROW + LP_ONE;
      default: w_src = w_src_base;
    endcase
  end

  assign o_pool_busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_pool_done = r_done;
  assign o_rd_valid  = r_valid;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    fmap_channel #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NPIX    (LP_PIX),
      .RELU_EN (RELU_EN)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_store     (w_st_ok && (i_out_c == CH_W'(k))),
      .i_first     (i_first),
      .i_st_addr   (i_w_addr),
      .i_bias      (i_bias),
      .i_value     (i_value),
      .i_load      (w_ld),
      .i_a1_ok     (w_a1_ok),
      .i_a2_ok     (w_a2_ok),
      .i_addr1     (i_addr1),
      .i_addr2     (i_addr2),
      .i_max_init  (r_state == S_RD0),
      .i_max_upd   ((r_state == S_RD1) || (r_state == S_RD2) || (r_state == S_RD3)),
      .i_pool_addr (w_src),
      .i_pool_wr   (r_state == S_WR),
      .i_dst_addr  (w_dst),
      .o_rd1       (w_rd1),
      .o_rd2       (w_rd2)
    );

    assign o_rd_data1[k*DATA_W +: DATA_W] = w_rd1;
    assign o_rd_data2[k*DATA_W +: DATA_W] = w_rd2;
  end

endmodule
